reg_wb_scheduler: RTL and testbench
===================================

Name: reg_wb_scheduler

Overview:
- Sequences writes into the 32x32 register file and tracks in-flight destination registers.
- Arbitrates two writeback sources onto the register file's single write port: source 0 is the ALU and source 1 is the load/store unit. Arbitration is round-robin.
- Keeps a per-register busy scoreboard and stalls issue on RAW and WAW hazards.
- Sits between decode/issue, the execution units, and the register file write port (regwrite, write_reg, write_data).

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register number width.
- DATA_W, 32, write data width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1  in  ADDR_W  source register 1.
- issue_rs2  in  ADDR_W  source register 2.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- issue_rd  in  ADDR_W  destination register.
- issue_wr_rd  in  1  instruction writes rd.
- issue_stall  out  1  combinational; the instruction must not issue this cycle.
- wb0_valid  in  1  ALU result valid.
- wb0_rd  in  ADDR_W  ALU destination.
- wb0_data  in  DATA_W  ALU result.
- wb0_ready  out  1  combinational grant to the ALU.
- wb1_valid  in  1  LSU result valid.
- wb1_rd  in  ADDR_W  LSU destination.
- wb1_data  in  DATA_W  LSU result.
- wb1_ready  out  1  combinational grant to the LSU.
- regwrite  out  1  registered write enable to the register file.
- write_reg  out  ADDR_W  registered write address.
- write_data  out  DATA_W  registered write data.
- busy_mask  out  NUM_REGS  scoreboard state; bit 0 is always 0.
- sb_err  out  1  sticky; a writeback targeted a non-busy register other than x0.

Behaviour:
- Reset. Reset is synchronous, active-high, on clock. It forces:
  - busy_mask = 0
  - regwrite = 0, write_reg = 0, write_data = 0
  - sb_err = 0
  - round-robin pointer = 0, so wb0 has priority first.
- Reset mid-operation discards every pending and in-flight write. wb_ready may still be asserted combinationally during reset, but nothing is recorded.
- Issue hazard check:
  - issue_stall = issue_valid & (raw1 | raw2 | waw).
  - raw1 = issue_use_rs1 & busy[rs1]; raw2 = issue_use_rs2 & busy[rs2]; waw = issue_wr_rd & busy[rd].
  - issue_fire = issue_valid & ~issue_stall & ~reset.
  - On issue_fire with issue_wr_rd = 1 and rd != 0, busy[rd] is set at the next edge.
- Writeback arbitration:
  - Exactly one source is granted per cycle.
  - If only one source is valid, that source is granted.
  - If both are valid, the source selected by the pointer is granted. After each two-way contention grant, the pointer moves to the other source.
  - A single-source grant leaves the pointer unchanged.
  - The transfer happens when wbN_valid & wbN_ready. An ungranted source holds valid, rd and data stable until granted.
- Write port:
  - On the edge that accepts a transfer, write_reg and write_data capture rd and data.
  - regwrite = 1 for exactly one cycle, only if rd != 0.
  - The register file writes on the following edge, giving 2 edges of latency from acceptance to the stored value.
  - With no transfer, regwrite = 0 and write_reg/write_data hold their values.
- Busy clear:
  - busy[write_reg] clears on the edge where regwrite = 1, which is the same edge the register file stores the value.
  - That register's bit is still 1 during the regwrite cycle, so a dependent instruction stalls through it. The earliest issue of a dependent instruction is the cycle after regwrite.
  - There is no bypass.
- Simultaneous events:
  - Set and clear of different registers on the same edge both take effect.
  - Set and clear of the same register cannot collide, because the WAW stall blocks the set.
- Writebacks to rd = 0 are accepted, produce no regwrite and raise no error.
- A writeback to rd != 0 whose busy bit is 0 at acceptance is still performed, and sets sb_err (sticky until reset).

Test Plan:
- Reset, then issue rd=5 (no sources) -> busy_mask = 0x00000020 next cycle. Issue of an instruction using rs1=5 -> issue_stall = 1.
- wb0 rd=5, data=0xDEADBEEF -> wb0_ready = 1. The following cycle regwrite = 1, write_reg = 5, write_data = 0xDEADBEEF, busy bit 5 = 0 after that edge. Dependent instruction issues the cycle after regwrite.
- wb0 and wb1 both valid for 4 cycles right after reset -> grants go wb0, wb1, wb0, wb1. Alone for 3 cycles, wb1 is granted every cycle.
- Issue rd=0, then wb1 rd=0, data=0x12 -> busy_mask stays 0, regwrite stays 0, sb_err = 0.
- wb0 rd=7 with busy[7] = 0 -> regwrite = 1 to register 7, sb_err = 1 and stays 1 until reset.
- Issue rd=3, rd=4, then assert reset alongside wb0 rd=3 valid -> next cycle busy_mask = 0, regwrite = 0, sb_err = 0.

Source files
------------

// File: rtl/reg_wb_scheduler.sv
// Writeback scheduler: round-robin merge of ALU/LSU results onto one regfile write port, plus a busy
// scoreboard that stalls RAW/WAW issue. Write port is registered (1 edge after grant); losers hold until granted.
module reg_wb_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_wr_rd,
  output logic                issue_stall,
  input  logic                wb0_valid,
  input  logic [ADDR_W-1:0]   wb0_rd,
  input  logic [DATA_W-1:0]   wb0_data,
  output logic                wb0_ready,
  input  logic                wb1_valid,
  input  logic [ADDR_W-1:0]   wb1_rd,
  input  logic [DATA_W-1:0]   wb1_data,
  output logic                wb1_ready,
  output logic                regwrite,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                sb_err
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rr_ptr;
  logic                raw1, raw2, waw;
  logic                issue_fire;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;

  assign busy_mask = busy;

  always_comb begin
    raw1        = issue_use_rs1 & busy[issue_rs1];
    raw2        = issue_use_rs2 & busy[issue_rs2];
    waw         = issue_wr_rd & busy[issue_rd];
    issue_stall = issue_valid & (raw1 | raw2 | waw);
    issue_fire  = issue_valid & ~issue_stall & ~reset;
  end

  // Pointer only matters under contention; a lone valid source always wins.
  always_comb begin
    wb0_ready = wb0_valid & (~wb1_valid | ~rr_ptr);
    wb1_ready = wb1_valid & (~wb0_valid | rr_ptr);
    xfer      = wb0_ready | wb1_ready;
    sel_rd    = wb1_ready ? wb1_rd   : wb0_rd;
    sel_data  = wb1_ready ? wb1_data : wb0_data;
  end

  // The clear lands on the same edge the regfile stores the value, so no bypass is ever needed.
  always_comb begin
    busy_nxt = busy;
    if (regwrite)
      busy_nxt[write_reg] = 1'b0;
    if (issue_fire && issue_wr_rd && (issue_rd != '0))
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy       <= '0;
      rr_ptr     <= 1'b0;
      regwrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      sb_err     <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      regwrite <= xfer && (sel_rd != '0);
      if (xfer) begin
        write_reg  <= sel_rd;
        write_data <= sel_data;
      end
      if (xfer && (sel_rd != '0) && !busy[sel_rd])
        sb_err <= 1'b1;
      if (wb0_valid && wb1_valid)
        rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench with grant/write scoreboards drained by a negedge monitor.
module tb_reg_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_wr_rd;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy_mask;
  logic        sb_err;

  int passed = 0;
  int total  = 0;

  int          exp_grant[$];
  logic [36:0] exp_write[$];

  always #5 clock = ~clock;

  reg_wb_scheduler dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_wr_rd(issue_wr_rd), .issue_stall(issue_stall),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .busy_mask(busy_mask), .sb_err(sb_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every observed grant and every regwrite must match the next expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if ((wb0_valid && wb0_ready) || (wb1_valid && wb1_ready)) begin
        if (exp_grant.size() == 0) check("unexpected_grant", {63'd0, wb1_ready}, 64'hFF);
        else check("grant_src", {62'd0, wb1_ready, wb0_ready}, (exp_grant.pop_front() == 1) ? 64'd2 : 64'd1);
      end
      if (regwrite) begin
        if (exp_write.size() == 0) check("unexpected_regwrite", {27'd0, write_reg, write_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("write_port", {27'd0, write_reg, write_data}, {27'd0, exp_write.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    sample();
    check("rst_busy", busy_mask, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_sb_err", sb_err, 0);

    // Issue rd=5, then a reader of x5 must stall
    step();
    issue_valid = 1; issue_wr_rd = 1; issue_rd = 5;
    sample();
    check("issue_rd5_nostall", issue_stall, 0);
    step();
    issue_wr_rd = 0; issue_rd = 0; issue_use_rs1 = 1; issue_rs1 = 5;
    sample();
    check("busy_rd5", busy_mask, 32'h0000_0020);
    check("raw_stall", issue_stall, 1);

    // Writeback x5; dependent stays presented throughout
    step();
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEAD_BEEF;
    exp_grant.push_back(0);
    exp_write.push_back({5'd5, 32'hDEAD_BEEF});
    sample();
    check("wb0_ready_single", wb0_ready, 1);
    step();
    wb0_valid = 0;
    sample();
    check("regwrite_cycle_stall", issue_stall, 1);
    check("regwrite_cycle_busy", busy_mask, 32'h0000_0020);
    step();
    sample();
    check("dep_issue_after_wb", issue_stall, 0);
    check("busy_cleared", busy_mask, 0);
    check("sb_err_clean", sb_err, 0);
    step();
    idle_inputs();

    // Round robin: both valid 4 cycles, then wb1 alone 3 cycles
    do_reset();
    wb0_valid = 1; wb0_rd = 1; wb0_data = 32'hA0A0_0001;
    wb1_valid = 1; wb1_rd = 2; wb1_data = 32'hB0B0_0002;
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(i % 2);
      exp_write.push_back((i % 2) ? {5'd2, 32'hB0B0_0002} : {5'd1, 32'hA0A0_0001});
    end
    repeat (4) step();
    wb0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      exp_grant.push_back(1);
      exp_write.push_back({5'd2, 32'hB0B0_0002});
    end
    repeat (3) step();
    wb1_valid = 0;
    step();
    sample();
    check("rr_sb_err_set", sb_err, 1);
    check("rr_queues_drained", exp_grant.size() + exp_write.size(), 0);

    // x0 traffic: no busy bit, no regwrite, no error
    do_reset();
    issue_valid = 1; issue_wr_rd = 1; issue_rd = 0;
    step();
    idle_inputs();
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'h12;
    exp_grant.push_back(1);
    sample();
    check("x0_busy", busy_mask, 0);
    check("x0_wb1_ready", wb1_ready, 1);
    step();
    wb1_valid = 0;
    sample();
    check("x0_regwrite", regwrite, 0);
    check("x0_sb_err", sb_err, 0);
    check("x0_write_reg", write_reg, 0);

    // Writeback to non-busy x7: performed and flagged, sticky
    step();
    wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h7777_0007;
    exp_grant.push_back(0);
    exp_write.push_back({5'd7, 32'h7777_0007});
    step();
    wb0_valid = 0;
    sample();
    check("x7_sb_err", sb_err, 1);
    repeat (3) step();
    sample();
    check("x7_sb_err_sticky", sb_err, 1);

    // Reset mid-flight discards pending writes and scoreboard
    step();
    issue_valid = 1; issue_wr_rd = 1; issue_rd = 3;
    step();
    issue_rd = 4;
    step();
    issue_valid = 0; issue_wr_rd = 0;
    sample();
    check("busy_3_4", busy_mask, 32'h0000_0018);
    step();
    reset = 1;
    wb0_valid = 1; wb0_rd = 3; wb0_data = 32'h3333_0003;
    step();
    reset = 0;
    wb0_valid = 0;
    sample();
    check("midrst_busy", busy_mask, 0);
    check("midrst_regwrite", regwrite, 0);
    check("midrst_sb_err", sb_err, 0);
    step();
    sample();
    check("final_queues_empty", exp_grant.size() + exp_write.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
